frame_dispatch_queue: RTL and testbench
=======================================

# frame_dispatch_queue

Parametrised pending-frame queue and dispatcher for the L2 switch simulator top. Collects user-built frames tagged with a source-port index. On a send request it drains them in FIFO order to per-port EndDevice transmit interfaces, one frame per cycle, gated by each port's ready. It replaces the fixed four-slot, all-at-once dispatch, where two frames for the same port overwrite each other.

## Interface
- NUM_PORTS, 4, number of EndDevice transmit ports (≥2)
- DEPTH, 4, queue entries (power of two, ≥2)
- FRAME_W, 16, frame width in bits
- PORT_W, 2, width of port index (2^PORT_W ≥ NUM_PORTS)
- TIMEOUT, 255, head-of-line wait limit in cycles (used only with FDQ_TIMEOUT_EN)
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- add_valid  in  1  one-cycle request to enqueue add_frame
- add_frame  in  FRAME_W  frame to enqueue
- add_port  in  PORT_W  destination transmit port index for add_frame
- send_req  in  1  one-cycle request to start draining
- tx_ready  in  NUM_PORTS  per-port: EndDevice can accept a frame
- tx_frame  out  NUM_PORTS*FRAME_W  per-port frame, port p at bits [p*FRAME_W +: FRAME_W]
- tx_valid  out  NUM_PORTS  per-port one-cycle transmit strobe
- count  out  $clog2(DEPTH+1)  entries held
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- busy  out  1  state is DRAIN
- drop  out  1  one-cycle pulse when a frame is discarded
- done  out  1  one-cycle pulse when a drain completes

## Operation
- Storage is a circular buffer with rd_ptr and wr_ptr (log2 DEPTH bits each, natural wrap) and a separate count. Each entry holds a frame and a port index.
- Enqueue: add_valid && !full && add_port < NUM_PORTS writes at wr_ptr, increments wr_ptr, and sets count+1.
- Enqueue with full, or with add_port ≥ NUM_PORTS: the frame is discarded, drop pulses, and the queue is unchanged.
- Enqueue is legal in both states. Frames added during DRAIN are also sent in the same drain.
- FSM states are IDLE and DRAIN.
  - IDLE → DRAIN: send_req && !empty.
  - send_req while empty: ignored, done not asserted.
  - send_req while in DRAIN: ignored.
- DRAIN, each cycle, head = entry at rd_ptr:
  - If tx_ready[head.port] is high: register tx_frame[head.port] ← head.frame, pulse tx_valid[head.port], pop (rd_ptr+1, count−1).
  - If tx_ready[head.port] is low: stall. There is no reordering, and later entries for other ports also wait.
- DRAIN → IDLE when the pop of the last entry leaves count == 0 with no simultaneous accepted enqueue. done pulses in the cycle after that pop, together with the final tx_valid.
- Simultaneous enqueue and pop in one cycle: count is unchanged and both pointers advance. full is evaluated from the registered count, so a push while full is dropped even if a pop occurs in the same cycle.
- At most one tx_valid bit is high in any cycle.
- tx_frame[p] holds its last value until overwritten.

## Timing
- All outputs are registered.
- Reset values:
  - tx_frame = 0, tx_valid = 0, count = 0, full = 0, empty = 1, busy = 0, drop = 0, done = 0
  - state IDLE, pointers 0
- add_valid at cycle N: count/full/empty update at N+1. drop, when applicable, is high at N+1.
- send_req at cycle N (IDLE, non-empty): busy = 1 at N+1, and the first tx_valid at N+2 if the head port is ready at N+1.
- Sustained throughput is one frame per cycle while the heads' ports are ready.
- rst asserted mid-drain: at the next edge the queue empties and all outputs take reset values. Queued frames are lost with no drop pulse.

## Configuration
- FDQ_TIMEOUT_EN defined:
  - In DRAIN, a wait counter increments every cycle the head is stalled and clears on any pop.
  - When it reaches TIMEOUT, the head is popped without tx_valid, drop pulses, and the counter clears.
- FDQ_TIMEOUT_EN undefined: no counter; DRAIN stalls indefinitely on a not-ready port.

## Test plan
- Reset, then add 4 frames (0x5ABx payload 1..4, ports 0,1,2,3), all tx_ready=1, send_req → tx_valid 0b0001,0b0010,0b0100,0b1000 on consecutive cycles with matching frames; done with the last; count returns to 0.
- Two frames to port 1 (0x5BA7, 0x5BA9), send_req → two tx_valid[1] pulses one cycle apart, tx_frame[1] = 0x5BA7 then 0x5BA9; neither frame lost.
- DEPTH=4: 5 adds → full=1 after the 4th, drop pulse on the 5th, count=4. An add with add_port=3 when NUM_PORTS=3 → drop, count unchanged.
- tx_ready[2]=0 with head for port 2 → busy stays 1 and no tx_valid. With FDQ_TIMEOUT_EN and TIMEOUT=8, drop occurs after 8 stalled cycles and draining resumes. Without it, raising tx_ready[2] at cycle 20 produces the strobe one cycle later.
- Wrap-around and concurrency: fill 3, drain 2, add 3 during DRAIN (pointers wrap) → all 4 remaining sent in FIFO order, single done.
- rst pulse while count=3 in DRAIN → next cycle count=0, empty=1, busy=0, no tx_valid; a new send_req is then ignored.

Source files
------------

// File: rtl/frame_dispatch_queue.sv
// frame_dispatch_queue: circular queue of port-tagged frames, drained in FIFO order one per cycle
// to per-port transmit interfaces. Define FDQ_TIMEOUT_EN to discard a head frame stalled for TIMEOUT cycles.
module frame_dispatch_queue #(
    parameter int NUM_PORTS = 4,
    parameter int DEPTH     = 4,
    parameter int FRAME_W   = 16,
    parameter int PORT_W    = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         add_valid,
    input  logic [FRAME_W-1:0]           add_frame,
    input  logic [PORT_W-1:0]            add_port,
    input  logic                         send_req,
    input  logic [NUM_PORTS-1:0]         tx_ready,
    output logic [NUM_PORTS*FRAME_W-1:0] tx_frame,
    output logic [NUM_PORTS-1:0]         tx_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         busy,
    output logic                         drop,
    output logic                         done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]   CNT_DEPTH = CW'(DEPTH);
    localparam logic [PORT_W:0] PORT_LIM  = (PORT_W+1)'(NUM_PORTS);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t                         state_r;
    logic [FRAME_W-1:0]             mem_frame_r [DEPTH];
    logic [PORT_W-1:0]              mem_port_r  [DEPTH];
    logic [AW-1:0]                  rd_ptr_r;
    logic [AW-1:0]                  wr_ptr_r;
    logic [CW-1:0]                  count_r;
    logic                           full_r;
    logic                           empty_r;
    logic                           busy_r;
    logic                           drop_r;
    logic                           done_r;
    logic [NUM_PORTS-1:0]           tx_valid_r;
    logic [NUM_PORTS*FRAME_W-1:0]   tx_frame_r;

    logic                           push_ok_s;
    logic                           push_drop_s;
    logic [FRAME_W-1:0]             head_frame_s;
    logic [PORT_W-1:0]              head_port_s;
    logic                           head_ready_s;
    logic                           draining_s;
    logic                           tx_pop_s;
    logic                           tmo_hit_s;
    logic                           pop_any_s;
    logic                           last_pop_s;
    logic [CW-1:0]                  count_nxt_s;
    logic [NUM_PORTS-1:0]           tx_valid_nxt_s;

    assign push_ok_s    = add_valid && !full_r && ({1'b0, add_port} < PORT_LIM);
    assign push_drop_s  = add_valid && !push_ok_s;
    assign head_frame_s = mem_frame_r[rd_ptr_r];
    assign head_port_s  = mem_port_r[rd_ptr_r];
    assign draining_s   = (state_r == ST_DRAIN);
    assign tx_pop_s     = draining_s && head_ready_s;
    assign pop_any_s    = tx_pop_s || tmo_hit_s;
    assign last_pop_s   = pop_any_s && (count_r == CNT_ONE) && !push_ok_s;

    // Head port readiness and the one-hot strobe the head would produce.
    always_comb begin
        head_ready_s   = 1'b0;
        tx_valid_nxt_s = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (head_port_s == PORT_W'(p)) begin
                head_ready_s      = tx_ready[p];
                tx_valid_nxt_s[p] = tx_pop_s;
            end else begin
                tx_valid_nxt_s[p] = 1'b0;
            end
        end
    end

    // Occupancy after this cycle's push and pop.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_any_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

`ifdef FDQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT+1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT-1);
    logic [TW-1:0] wait_cnt_r;

    // The stall that would bring the counter to TIMEOUT discards the head instead.
    assign tmo_hit_s = draining_s && !head_ready_s && (wait_cnt_r == TMO_LAST);

    // Head-of-line wait counter, cleared on any pop or outside DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= '0;
        end else if (!draining_s || pop_any_s) begin
            wait_cnt_r <= '0;
        end else begin
            wait_cnt_r <= wait_cnt_r + TW'(1);
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Queue storage, pointers, FSM and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= '0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            busy_r     <= 1'b0;
            drop_r     <= 1'b0;
            done_r     <= 1'b0;
            tx_valid_r <= '0;
            tx_frame_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_frame_r[i] <= '0;
                mem_port_r[i]  <= '0;
            end
        end else begin
            if (push_ok_s) begin
                mem_frame_r[wr_ptr_r] <= add_frame;
                mem_port_r[wr_ptr_r]  <= add_port;
                wr_ptr_r              <= wr_ptr_r + PTR_ONE;
            end
            if (pop_any_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r    <= count_nxt_s;
            full_r     <= (count_nxt_s == CNT_DEPTH);
            empty_r    <= (count_nxt_s == '0);
            drop_r     <= push_drop_s || tmo_hit_s;
            tx_valid_r <= tx_valid_nxt_s;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (tx_valid_nxt_s[p]) begin
                    tx_frame_r[p*FRAME_W +: FRAME_W] <= head_frame_s;
                end
            end
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (send_req && !empty_r) begin
                        state_r <= ST_DRAIN;
                        busy_r  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (last_pop_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_frame = tx_frame_r;
    assign tx_valid = tx_valid_r;
    assign count    = count_r;
    assign full     = full_r;
    assign empty    = empty_r;
    assign busy     = busy_r;
    assign drop     = drop_r;
    assign done     = done_r;

endmodule

// File: tb/tb_frame_dispatch_queue.sv
// Directed bench for frame_dispatch_queue: FIFO dispatch, same-port ordering, full/invalid drops,
// head-of-line stall, pointer wrap with concurrent enqueue, and mid-drain reset.
module tb_frame_dispatch_queue;
    localparam int NP = 4;
    localparam int FW = 16;
    localparam int PW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              add_valid;
    logic [FW-1:0]     add_frame;
    logic [PW-1:0]     add_port;
    logic              send_req;
    logic [NP-1:0]     tx_ready;
    logic [NP*FW-1:0]  tx_frame;
    logic [NP-1:0]     tx_valid;
    logic [2:0]        count;
    logic              full, empty, busy, drop, done;

    logic              add_valid3;
    logic [FW-1:0]     add_frame3;
    logic [PW-1:0]     add_port3;
    logic              send_req3;
    logic [2:0]        tx_ready3;
    logic [3*FW-1:0]   tx_frame3;
    logic [2:0]        tx_valid3;
    logic [2:0]        count3;
    logic              full3, empty3, busy3, drop3, done3;

    int pass_cnt  = 0;
    int total_cnt = 0;

    frame_dispatch_queue #(.NUM_PORTS(NP), .DEPTH(4), .FRAME_W(FW), .PORT_W(PW), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .add_valid(add_valid), .add_frame(add_frame), .add_port(add_port),
        .send_req(send_req), .tx_ready(tx_ready), .tx_frame(tx_frame), .tx_valid(tx_valid),
        .count(count), .full(full), .empty(empty), .busy(busy), .drop(drop), .done(done)
    );

    frame_dispatch_queue #(.NUM_PORTS(3), .DEPTH(4), .FRAME_W(FW), .PORT_W(PW), .TIMEOUT(255)) dut3 (
        .clk(clk), .rst(rst), .add_valid(add_valid3), .add_frame(add_frame3), .add_port(add_port3),
        .send_req(send_req3), .tx_ready(tx_ready3), .tx_frame(tx_frame3), .tx_valid(tx_valid3),
        .count(count3), .full(full3), .empty(empty3), .busy(busy3), .drop(drop3), .done(done3)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observed status word {busy,done,drop,full,empty,count,tx_valid}.
    function automatic logic [11:0] st();
        return {busy, done, drop, full, empty, count, tx_valid};
    endfunction

    function automatic logic [11:0] mk(bit b, bit d, bit dr, bit f, bit e, int c, logic [3:0] v);
        logic [2:0] c3;
        c3 = c[2:0];
        return {b, d, dr, f, e, c3, v};
    endfunction

    task automatic add(input logic [FW-1:0] f, input logic [PW-1:0] p);
        add_valid = 1'b1; add_frame = f; add_port = p;
        tick();
        add_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] e;
        rst = 1'b1; add_valid = 1'b0; add_frame = '0; add_port = '0; send_req = 1'b0; tx_ready = '0;
        add_valid3 = 1'b0; add_frame3 = '0; add_port3 = '0; send_req3 = 1'b0; tx_ready3 = '0;
        tick(); tick();
        rst = 1'b0;
        e = mk(0, 0, 0, 0, 1, 0, 4'b0000);
        total_cnt++; if (st() !== e) $display("FAIL reset_status: got %b expected %b", st(), e); else pass_cnt++;
        total_cnt++; if (tx_frame !== '0) $display("FAIL reset_frame: got %h expected 0", tx_frame); else pass_cnt++;
        send_req = 1'b1; tick(); send_req = 1'b0;
        total_cnt++; if (st() !== e) $display("FAIL send_empty: got %b expected %b", st(), e); else pass_cnt++;
        tick();
        total_cnt++; if (st() !== e) $display("FAIL send_empty_after: got %b expected %b", st(), e); else pass_cnt++;
    endtask

    task automatic test_in_order();
        logic [11:0]   e;
        logic [FW-1:0] ef;
        tx_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            ef = 16'h5AB1 + 16'(i);
            add(ef, PW'(i));
            e = mk(0, 0, 0, i == 3, 0, i + 1, 4'b0000);
            total_cnt++; if (st() !== e) $display("FAIL order_add%0d: got %b expected %b", i, st(), e); else pass_cnt++;
        end
        send_req = 1'b1; tick(); send_req = 1'b0;
        e = mk(1, 0, 0, 1, 0, 4, 4'b0000);
        total_cnt++; if (st() !== e) $display("FAIL order_busy: got %b expected %b", st(), e); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            tick();
            ef = 16'h5AB1 + 16'(i);
            e = mk(i != 3, i == 3, 0, 0, i == 3, 3 - i, 4'(1 << i));
            total_cnt++; if (st() !== e) $display("FAIL order_tx%0d: got %b expected %b", i, st(), e); else pass_cnt++;
            total_cnt++; if (tx_frame[i*FW +: FW] !== ef) $display("FAIL order_frame%0d: got %h expected %h", i, tx_frame[i*FW +: FW], ef); else pass_cnt++;
        end
        tick();
        e = mk(0, 0, 0, 0, 1, 0, 4'b0000);
        total_cnt++; if (st() !== e) $display("FAIL order_idle: got %b expected %b", st(), e); else pass_cnt++;
    endtask

    task automatic test_same_port();
        logic [11:0] e;
        tx_ready = 4'b1111;
        add(16'h5BA7, 2'd1);
        add(16'h5BA9, 2'd1);
        send_req = 1'b1; tick(); send_req = 1'b0;
        tick();
        e = mk(1, 0, 0, 0, 0, 1, 4'b0010);
        total_cnt++; if (st() !== e) $display("FAIL same_first: got %b expected %b", st(), e); else pass_cnt++;
        total_cnt++; if (tx_frame[FW +: FW] !== 16'h5BA7) $display("FAIL same_frame1: got %h expected 5ba7", tx_frame[FW +: FW]); else pass_cnt++;
        tick();
        e = mk(0, 1, 0, 0, 1, 0, 4'b0010);
        total_cnt++; if (st() !== e) $display("FAIL same_second: got %b expected %b", st(), e); else pass_cnt++;
        total_cnt++; if (tx_frame[FW +: FW] !== 16'h5BA9) $display("FAIL same_frame2: got %h expected 5ba9", tx_frame[FW +: FW]); else pass_cnt++;
        total_cnt++; if (tx_frame[0 +: FW] !== 16'h5AB1) $display("FAIL same_hold0: got %h expected 5ab1", tx_frame[0 +: FW]); else pass_cnt++;
    endtask

    task automatic test_full_drop();
        logic [11:0] e;
        tx_ready = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            add(16'h00F0 + 16'(i), 2'd0);
            e = (i < 4) ? mk(0, 0, 0, i == 3, 0, i + 1, 4'b0000) : mk(0, 0, 1, 1, 0, 4, 4'b0000);
            total_cnt++; if (st() !== e) $display("FAIL full_add%0d: got %b expected %b", i, st(), e); else pass_cnt++;
        end
        tick();
        e = mk(0, 0, 0, 1, 0, 4, 4'b0000);
        total_cnt++; if (st() !== e) $display("FAIL full_drop_end: got %b expected %b", st(), e); else pass_cnt++;
        send_req = 1'b1; tick(); send_req = 1'b0;
        tick(); tick(); tick(); tick();
        e = mk(0, 1, 0, 0, 1, 0, 4'b0001);
        total_cnt++; if (st() !== e) $display("FAIL full_drain: got %b expected %b", st(), e); else pass_cnt++;
        total_cnt++; if (tx_frame[0 +: FW] !== 16'h00F3) $display("FAIL full_last_frame: got %h expected 00f3", tx_frame[0 +: FW]); else pass_cnt++;
        // Three-port instance: port index 3 is out of range.
        add_valid3 = 1'b1; add_frame3 = 16'h0BAD; add_port3 = 2'd3;
        tick();
        add_valid3 = 1'b0;
        total_cnt++; if ({drop3, count3} !== {1'b1, 3'd0}) $display("FAIL bad_port: got drop=%b count=%0d expected drop=1 count=0", drop3, count3); else pass_cnt++;
        add_valid3 = 1'b1; add_frame3 = 16'h0600; add_port3 = 2'd2;
        tick();
        add_valid3 = 1'b0;
        total_cnt++; if ({drop3, count3} !== {1'b0, 3'd1}) $display("FAIL good_port2: got drop=%b count=%0d expected drop=0 count=1", drop3, count3); else pass_cnt++;
    endtask

    task automatic test_stall();
        logic [11:0] e;
        int          bad;
        tx_ready = 4'b1011;
        add(16'h2C2C, 2'd2);
        add(16'h0D0D, 2'd0);
        send_req = 1'b1; tick(); send_req = 1'b0;
        e = mk(1, 0, 0, 0, 0, 2, 4'b0000);
        bad = 0;
        for (int i = 0; i < 18; i++) begin
            if (st() !== e) bad++;
            tick();
        end
        total_cnt++; if (bad != 0) $display("FAIL stall_hold: got %0d deviating cycles expected 0", bad); else pass_cnt++;
        total_cnt++; if (st() !== e) $display("FAIL stall_last: got %b expected %b", st(), e); else pass_cnt++;
        tx_ready = 4'b1111;
        tick();
        e = mk(1, 0, 0, 0, 0, 1, 4'b0100);
        total_cnt++; if (st() !== e) $display("FAIL stall_release: got %b expected %b", st(), e); else pass_cnt++;
        total_cnt++; if (tx_frame[2*FW +: FW] !== 16'h2C2C) $display("FAIL stall_frame2: got %h expected 2c2c", tx_frame[2*FW +: FW]); else pass_cnt++;
        tick();
        e = mk(0, 1, 0, 0, 1, 0, 4'b0001);
        total_cnt++; if (st() !== e) $display("FAIL stall_next: got %b expected %b", st(), e); else pass_cnt++;
        total_cnt++; if (tx_frame[0 +: FW] !== 16'h0D0D) $display("FAIL stall_frame0: got %h expected 0d0d", tx_frame[0 +: FW]); else pass_cnt++;
    endtask

    task automatic test_wrap_concurrent();
        logic [11:0]   e;
        logic [FW-1:0] ef;
        logic [FW-1:0] exp_frames [4];
        int            exp_ports  [4];
        exp_frames = '{16'hA003, 16'hB001, 16'hB002, 16'hB003};
        exp_ports  = '{2, 3, 1, 0};
        tx_ready = 4'b1111;
        add(16'hA001, 2'd0); add(16'hA002, 2'd1); add(16'hA003, 2'd2);
        send_req = 1'b1; tick(); send_req = 1'b0;
        e = mk(1, 0, 0, 0, 0, 3, 4'b0000);
        total_cnt++; if (st() !== e) $display("FAIL wrap_busy: got %b expected %b", st(), e); else pass_cnt++;
        tick();
        e = mk(1, 0, 0, 0, 0, 2, 4'b0001);
        total_cnt++; if (st() !== e) $display("FAIL wrap_pop1: got %b expected %b", st(), e); else pass_cnt++;
        add(16'hB001, 2'd3);
        e = mk(1, 0, 0, 0, 0, 2, 4'b0010);
        total_cnt++; if (st() !== e) $display("FAIL wrap_pushpop: got %b expected %b", st(), e); else pass_cnt++;
        total_cnt++; if (tx_frame[FW +: FW] !== 16'hA002) $display("FAIL wrap_frameA2: got %h expected a002", tx_frame[FW +: FW]); else pass_cnt++;
        tx_ready = 4'b0000;
        add(16'hB002, 2'd1);
        add(16'hB003, 2'd0);
        e = mk(1, 0, 0, 1, 0, 4, 4'b0000);
        total_cnt++; if (st() !== e) $display("FAIL wrap_full: got %b expected %b", st(), e); else pass_cnt++;
        tx_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            ef = exp_frames[i];
            e = mk(i != 3, i == 3, 0, 0, i == 3, 3 - i, 4'(1 << exp_ports[i]));
            total_cnt++; if (st() !== e) $display("FAIL wrap_tx%0d: got %b expected %b", i, st(), e); else pass_cnt++;
            total_cnt++; if (tx_frame[exp_ports[i]*FW +: FW] !== ef) $display("FAIL wrap_frame%0d: got %h expected %h", i, tx_frame[exp_ports[i]*FW +: FW], ef); else pass_cnt++;
        end
        tick();
        e = mk(0, 0, 0, 0, 1, 0, 4'b0000);
        total_cnt++; if (st() !== e) $display("FAIL wrap_single_done: got %b expected %b", st(), e); else pass_cnt++;
    endtask

    task automatic test_reset_mid_drain();
        logic [11:0] e;
        tx_ready = 4'b0000;
        add(16'hC001, 2'd0); add(16'hC002, 2'd1); add(16'hC003, 2'd2);
        send_req = 1'b1; tick(); send_req = 1'b0;
        e = mk(1, 0, 0, 0, 0, 3, 4'b0000);
        total_cnt++; if (st() !== e) $display("FAIL mid_busy: got %b expected %b", st(), e); else pass_cnt++;
        rst = 1'b1; tick(); rst = 1'b0;
        e = mk(0, 0, 0, 0, 1, 0, 4'b0000);
        total_cnt++; if (st() !== e) $display("FAIL mid_reset: got %b expected %b", st(), e); else pass_cnt++;
        total_cnt++; if (tx_frame !== '0) $display("FAIL mid_reset_frame: got %h expected 0", tx_frame); else pass_cnt++;
        tx_ready = 4'b1111;
        send_req = 1'b1; tick(); send_req = 1'b0;
        total_cnt++; if (st() !== e) $display("FAIL mid_send_ignored: got %b expected %b", st(), e); else pass_cnt++;
        tick();
        total_cnt++; if (st() !== e) $display("FAIL mid_quiet: got %b expected %b", st(), e); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_same_port();
        test_full_drop();
        test_stall();
        test_wrap_concurrent();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
